imuldiv_muldiv_iter_responder: RTL and testbench
================================================

// Module: imuldiv_muldiv_iter_responder
// PURPOSE
//  Iterative 32-bit integer mul/div responder. Serves the muldivreq/muldivresp
//  val/rdy interface driven by the request side: one request in flight,
//  shift-add multiply, shift-subtract divide, 64-bit result returned.
//  Sits between a core/test source and its writeback/test sink.
// PARAMETERS
//  NBITS   32   operand width; result is 2*NBITS
//  NITERS  32   iterations per op (== NBITS)
// PORTS
//  clk                    in   1   clock, all state on posedge
//  reset_n                in   1   asynchronous, active-low reset
//  muldivreq_msg_fn       in   3   0=MUL, 1=DIV/REM signed, 2=DIVU/REMU
//  muldivreq_msg_a        in   32  operand A (multiplicand / dividend)
//  muldivreq_msg_b        in   32  operand B (multiplier / divisor)
//  muldivreq_val          in   1   request valid
//  muldivreq_rdy          out  1   request ready
//  muldivresp_msg_result  out  64  MUL: full product; DIV*: {rem[31:0],quot[31:0]}
//  muldivresp_val         out  1   response valid
//  muldivresp_rdy         in   1   response ready
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, counter=0, result reg=0,
//    muldivresp_val=0, muldivreq_rdy=0 while reset_n low; rdy=1 in IDLE after.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: rdy=1. req_val&rdy on an edge latches fn, |a|, |b|, sign_a, sign_b
//      (signs only for fn 0/1; fn 2 uses raw operands, signs forced 0); -> CALC.
//    CALC: rdy=0, resp_val=0; one iteration per cycle, counter 0..31; after
//      iteration 31 apply sign fix into result reg; -> DONE.
//    DONE: resp_val=1, result stable; resp_val&resp_rdy -> IDLE.
//      No new request accepted in DONE (no overlap); earliest next accept is
//      the cycle after the response handshake.
//  - Latency: resp_val rises exactly 33 edges after the accepting edge,
//    independent of operand values (no early-out).
//  - MUL: 64-bit acc; each step adds (a<<i) if b[i]; result negated iff
//    sign_a^sign_b. Low/high 32 bits are MUL/MULH semantics.
//  - DIV: 65-bit {rem,quot} shift reg; shift left, subtract |b| if no borrow,
//    set quot bit. Signed fix: quot negated iff sign_a^sign_b; rem takes sign_a.
//  - Divide by zero (b==0, fn 1 or 2): result = {a, 32'hffffffff}, still 33-cycle
//    latency (iterations run, result overridden at fix step).
//  - Signed overflow 0x80000000 / 0xffffffff: result {0, 0x80000000}, no special path.
//  - fn 3..7: accepted, result 64'h0, same latency.
//  - Inputs change while rdy=0: ignored. resp_rdy held low: DONE held indefinitely,
//    result unchanged.
//  - reset_n asserted mid-CALC or mid-DONE: op discarded, resp_val drops
//    immediately (async); no response is ever issued for that request.
// STRUCTURE
//  - Shared header imuldiv-MulDivReqMsg.v: fn encodings (MUL=0, DIV=1, DIVU=2),
//    request bit-field widths/positions; not redefined locally.
//  - State encodings and counter width local localparams.
//  - One sub-module: imuldiv_muldiv_iter_dpath (operand/acc/shift regs, adder/
//    subtractor, sign fix, div-by-zero mux); control FSM + counter in this file.
// TESTING (val/rdy test source/sink with random delays, 67-bit req msgs)
//  1 MUL 0xfffffff8 x 0x00000008 -> 64'hffffffff_ffffffc0; 0xdeadbeef x
//    0x10000000 -> 64'hfdeadbee_f0000000.
//  2 DIV 0x0a01b044 / 0xffffb14a -> 64'h00003372_ffffdf75; 0xf5fe4fbc / 0xffffb14a
//    -> 64'hffffcc8e_0000208b.
//  3 DIVU 0xffffffff / 0x00000002 -> 64'h00000001_7fffffff; DIV by 0, a=0x12345678
//    -> 64'h12345678_ffffffff; DIV 0x80000000/0xffffffff -> 64'h00000000_80000000.
//  4 Latency/handshake: single MUL, resp_rdy=1 -> resp_val rises exactly 33 edges
//    after accept; rdy=0 throughout CALC/DONE; resp_rdy held 0 for 10 cycles ->
//    result and val stable, next req accepted only after handshake.
//  5 Reset mid-op: assert reset_n=0 at iteration 10 of a DIV -> resp_val=0,
//    rdy=0 during reset; after release next MUL 3x8 -> 64'h18, no stale response.
//  6 Back-to-back mixed MUL/DIV/DIVU stream (12 msgs) -> sink sees all in order.

Source files
------------

// File: rtl/imuldiv_muldiv_iter_responder_pkg.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_iter_responder_pkg
//   Shared definitions for the iterative mul/div responder:
//   - function-code encodings carried in muldivreq_msg_fn
//   - request message field widths/positions (fn | a | b, 67 bits total)
//   - small helper for two's-complement magnitude
// ---------------------------------------------------------------------------
package imuldiv_muldiv_iter_responder_pkg;

    // Function code field
    localparam int FN_W = 3;
    localparam logic [FN_W-1:0] FN_MUL  = 3'd0;  // signed multiply, full product
    localparam logic [FN_W-1:0] FN_DIV  = 3'd1;  // signed divide / remainder
    localparam int FN_DIVU_VAL = 2;
    localparam logic [FN_W-1:0] FN_DIVU = 3'(FN_DIVU_VAL);  // unsigned divide / remainder

    // Request message layout: {fn, a, b}
    localparam int REQ_OP_W   = 32;
    localparam int REQ_MSG_W  = FN_W + 2 * REQ_OP_W;
    localparam int REQ_B_LSB  = 0;
    localparam int REQ_A_LSB  = REQ_OP_W;
    localparam int REQ_FN_LSB = 2 * REQ_OP_W;

    // Response message width: {rem, quot} or full product
    localparam int RESP_MSG_W = 2 * REQ_OP_W;

    // True when the function interprets its operands as signed values.
    function automatic logic fn_is_signed(input logic [FN_W-1:0] fn);
        return (fn == FN_MUL) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_iter_dpath.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_iter_dpath
//   Datapath for the iterative mul/div responder. Holds operand magnitudes and
//   signs, a shift-add multiply accumulator, a shift-subtract {rem,quot}
//   register, and the final result register with sign fix and divide-by-zero
//   override. Sequencing comes entirely from the control FSM.
//
// Ports
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   load     in   capture fn/a/b and initialise the iteration registers
//   step     in   perform one multiply and one divide iteration
//   fix      in   apply sign fix / overrides into the result register
//   fn       in   function code (see package)
//   a, b     in   operands
//   result   out  result register (2*NBITS)
// ---------------------------------------------------------------------------
module imuldiv_muldiv_iter_dpath
    import imuldiv_muldiv_iter_responder_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic [FN_W-1:0]      fn,
    input  logic [NBITS-1:0]     a,
    input  logic [NBITS-1:0]     b,
    output logic [2*NBITS-1:0]   result
);

    // Captured operation context
    logic [FN_W-1:0]    fn_reg;
    logic [NBITS-1:0]   a_raw_reg;     // raw dividend, returned on divide by zero
    logic [NBITS-1:0]   b_abs_reg;     // divisor magnitude
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic               b_zero_reg;

    // Multiply: multiplicand shifts left, multiplier shifts right each step
    logic [2*NBITS-1:0] mcand_reg;
    logic [NBITS-1:0]   mplier_reg;
    logic [2*NBITS-1:0] acc_reg;

    // Divide: {rem, quot}. The shifted value is 2*NBITS+1 wide; the stored
    // remainder is always below |b| so its top bit never needs keeping.
    logic [2*NBITS-1:0] rq_reg;

    logic [2*NBITS-1:0] result_reg;

    // Load-time operand conditioning: unsigned ops use raw bits, signs forced 0
    logic               sign_a_in;
    logic               sign_b_in;
    logic [NBITS-1:0]   a_abs_in;
    logic [NBITS-1:0]   b_abs_in;

    assign sign_a_in = fn_is_signed(fn) & a[NBITS-1];
    assign sign_b_in = fn_is_signed(fn) & b[NBITS-1];
    assign a_abs_in  = sign_a_in ? (~a + 1'b1) : a;
    assign b_abs_in  = sign_b_in ? (~b + 1'b1) : b;

    // One multiply iteration
    logic [2*NBITS-1:0] acc_next;
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // One restoring-divide iteration: shift, trial subtract, keep on no borrow
    logic [2*NBITS:0]   rq_shift;
    logic [NBITS:0]     diff;
    logic [2*NBITS-1:0] rq_next;

    assign rq_shift = {rq_reg, 1'b0};
    assign diff     = rq_shift[2*NBITS:NBITS] - {1'b0, b_abs_reg};
    assign rq_next  = diff[NBITS] ? rq_shift[2*NBITS-1:0]
                                  : {diff[NBITS-1:0], rq_shift[NBITS-1:1], 1'b1};

    // Final sign fix and result selection
    logic [NBITS-1:0]   quot;
    logic [NBITS-1:0]   rem;
    logic [NBITS-1:0]   quot_fix;
    logic [NBITS-1:0]   rem_fix;
    logic [2*NBITS-1:0] prod_fix;
    logic [2*NBITS-1:0] fixed_result;

    assign quot     = rq_reg[NBITS-1:0];
    assign rem      = rq_reg[2*NBITS-1:NBITS];
    assign quot_fix = (sign_a_reg ^ sign_b_reg) ? (~quot + 1'b1) : quot;
    assign rem_fix  = sign_a_reg ? (~rem + 1'b1) : rem;
    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;

    always_comb begin
        fixed_result = '0;
        case (fn_reg)
            FN_MUL:          fixed_result = prod_fix;
            FN_DIV, FN_DIVU: fixed_result = b_zero_reg ? {a_raw_reg, {NBITS{1'b1}}}
                                                       : {rem_fix, quot_fix};
            default:         fixed_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fn_reg     <= '0;
            a_raw_reg  <= '0;
            b_abs_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            rq_reg     <= '0;
            result_reg <= '0;
        end else if (load) begin
            fn_reg     <= fn;
            a_raw_reg  <= a;
            b_abs_reg  <= b_abs_in;
            sign_a_reg <= sign_a_in;
            sign_b_reg <= sign_b_in;
            b_zero_reg <= (b == '0);
            mcand_reg  <= {{NBITS{1'b0}}, a_abs_in};
            mplier_reg <= b_abs_in;
            acc_reg    <= '0;
            rq_reg     <= {{NBITS{1'b0}}, a_abs_in};
        end else if (step) begin
            // Both algorithms advance every step; fix selects the relevant one.
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[2*NBITS-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[NBITS-1:1]};
            rq_reg     <= rq_next;
        end else if (fix) begin
            result_reg <= fixed_result;
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/imuldiv_muldiv_iter_responder.sv
// ---------------------------------------------------------------------------
// imuldiv_muldiv_iter_responder
//   Iterative integer mul/div responder on a val/rdy request/response pair.
//   One request in flight. Every operation takes NITERS iteration cycles plus
//   one sign-fix cycle, so the response is valid exactly NITERS+1 edges after
//   the accepting edge, regardless of operand values.
//
// Ports
//   clk                    in   clock
//   reset_n                in   asynchronous active-low reset
//   muldivreq_msg_fn       in   0=MUL, 1=DIV/REM, 2=DIVU/REMU, others -> 0
//   muldivreq_msg_a        in   operand A
//   muldivreq_msg_b        in   operand B
//   muldivreq_val          in   request valid
//   muldivreq_rdy          out  request ready (registered)
//   muldivresp_msg_result  out  MUL: product; DIV*: {rem, quot}
//   muldivresp_val         out  response valid (registered)
//   muldivresp_rdy         in   response ready
// ---------------------------------------------------------------------------
module imuldiv_muldiv_iter_responder
    import imuldiv_muldiv_iter_responder_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int NITERS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [FN_W-1:0]      muldivreq_msg_fn,
    input  logic [NBITS-1:0]     muldivreq_msg_a,
    input  logic [NBITS-1:0]     muldivreq_msg_b,
    input  logic                 muldivreq_val,
    output logic                 muldivreq_rdy,
    output logic [2*NBITS-1:0]   muldivresp_msg_result,
    output logic                 muldivresp_val,
    input  logic                 muldivresp_rdy
);

    localparam int CNT_W = $clog2(NITERS + 1);
    // Counter value at which the iterations are finished and the fix applies
    localparam logic [CNT_W-1:0] CNT_FIX = CNT_W'(NITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             rdy_reg;
    logic             resp_val_reg;

    logic             req_fire;
    logic             calc_step;
    logic             calc_fix;

    // rdy_reg is only ever high in IDLE, so it alone qualifies acceptance.
    assign req_fire  = (state_reg == ST_IDLE) && rdy_reg && muldivreq_val;
    assign calc_step = (state_reg == ST_CALC) && (count_reg != CNT_FIX);
    assign calc_fix  = (state_reg == ST_CALC) && (count_reg == CNT_FIX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            rdy_reg      <= 1'b0;
            resp_val_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Ready comes up on the first edge after reset release.
                    rdy_reg <= !req_fire;
                    if (req_fire) begin
                        state_reg <= ST_CALC;
                        count_reg <= '0;
                    end
                end
                ST_CALC: begin
                    rdy_reg      <= 1'b0;
                    resp_val_reg <= 1'b0;
                    if (calc_fix) begin
                        state_reg    <= ST_DONE;
                        count_reg    <= '0;
                        resp_val_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (muldivresp_rdy) begin
                        state_reg    <= ST_IDLE;
                        resp_val_reg <= 1'b0;
                        rdy_reg      <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    count_reg    <= '0;
                    rdy_reg      <= 1'b0;
                    resp_val_reg <= 1'b0;
                end
            endcase
        end
    end

    imuldiv_muldiv_iter_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (req_fire),
        .step    (calc_step),
        .fix     (calc_fix),
        .fn      (muldivreq_msg_fn),
        .a       (muldivreq_msg_a),
        .b       (muldivreq_msg_b),
        .result  (muldivresp_msg_result)
    );

    assign muldivreq_rdy  = rdy_reg;
    assign muldivresp_val = resp_val_reg;

endmodule

// File: tb/tb_imuldiv_muldiv_iter_responder.sv
module tb_imuldiv_muldiv_iter_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a;
    logic [31:0] muldivreq_msg_b;
    logic        muldivreq_val;
    logic        muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    always #5 clk = ~clk;

    imuldiv_muldiv_iter_responder dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' meaning.
    function automatic logic [63:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, prod, q, r;
        logic [31:0] uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (fn)
            3'd0: begin
                prod = sa * sb;
                res  = 64'(prod);
            end
            3'd1: begin
                if (b == 32'd0) res = {a, 32'hffffffff};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hffffffff};
                else begin
                    uq  = a / b;
                    ur  = a % b;
                    res = {ur, uq};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) for the accepting edge.
    task automatic start_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output logic accepted);
        logic r;
        accepted         = 1'b0;
        muldivreq_msg_fn = fn;
        muldivreq_msg_a  = a;
        muldivreq_msg_b  = b;
        muldivreq_val    = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            r = muldivreq_rdy;
            tick();
            if (r) accepted = 1'b1;
        end
        check_val("accept", 64'(accepted), 64'd1);
        muldivreq_val    = 1'b0;
        // Scramble inputs: must be ignored while busy.
        muldivreq_msg_fn = 3'($urandom);
        muldivreq_msg_a  = $urandom;
        muldivreq_msg_b  = $urandom;
    endtask

    task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic        accepted;
        logic [63:0] exp;
        int          lat, rdy_seen, unstable;
        exp = ref_model(fn, a, b);
        start_op(fn, a, b, accepted);
        if (!accepted) return;
        lat = 0;
        rdy_seen = 0;
        while (!muldivresp_val && lat < 100) begin
            tick();
            lat++;
            if (muldivreq_rdy) rdy_seen++;
        end
        check_val("latency", 64'(lat), 64'd33);
        check_val("rdy_busy", 64'(rdy_seen), 64'd0);
        check_val("result", muldivresp_msg_result, exp);
        $display("txn %0d fn=%0d a=%h b=%h result=%h exp=%h lat=%0d hold=%0d",
                 txn_no, fn, a, b, muldivresp_msg_result, exp, lat, hold);
        txn_no++;
        // Hold the response with a competing request presented: nothing may change.
        unstable = 0;
        if (hold > 0) begin
            muldivreq_val = 1'b1;
            for (int k = 0; k < hold; k++) begin
                tick();
                if (muldivresp_msg_result !== exp || muldivresp_val !== 1'b1 ||
                    muldivreq_rdy !== 1'b0) unstable++;
            end
            muldivreq_val = 1'b0;
            check_val("hold_stable", 64'(unstable), 64'd0);
        end
        muldivresp_rdy = 1'b1;
        tick();
        muldivresp_rdy = 1'b0;
        check_val("val_after_hs", 64'(muldivresp_val), 64'd0);
        check_val("rdy_after_hs", 64'(muldivreq_rdy), 64'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        acc;
        logic [2:0]  rfn;
        int          stale;

        reset_n          = 1'b0;
        muldivreq_msg_fn = '0;
        muldivreq_msg_a  = '0;
        muldivreq_msg_b  = '0;
        muldivreq_val    = 1'b0;
        muldivresp_rdy   = 1'b0;
        repeat (3) tick();
        check_val("rst_rdy", 64'(muldivreq_rdy), 64'd0);
        check_val("rst_val", 64'(muldivresp_val), 64'd0);
        check_val("rst_result", muldivresp_msg_result, 64'd0);
        reset_n = 1'b1;
        tick();
        check_val("rdy_after_rst", 64'(muldivreq_rdy), 64'd1);

        // Directed vectors with constant expectations
        do_op(3'd0, 32'hfffffff8, 32'h00000008, 0);
        check_val("mul_neg8x8", muldivresp_msg_result, 64'hffffffff_ffffffc0);
        do_op(3'd0, 32'hdeadbeef, 32'h10000000, 1);
        check_val("mul_deadbeef", muldivresp_msg_result, 64'hfdeadbee_f0000000);
        do_op(3'd1, 32'h0a01b044, 32'hffffb14a, 0);
        check_val("div_pos_neg", muldivresp_msg_result, 64'h00003372_ffffdf75);
        do_op(3'd1, 32'hf5fe4fbc, 32'hffffb14a, 0);
        check_val("div_neg_neg", muldivresp_msg_result, 64'hffffcc8e_0000208b);
        do_op(3'd2, 32'hffffffff, 32'h00000002, 0);
        check_val("divu", muldivresp_msg_result, 64'h00000001_7fffffff);
        do_op(3'd1, 32'h12345678, 32'h00000000, 0);
        check_val("div_by_zero", muldivresp_msg_result, 64'h12345678_ffffffff);
        do_op(3'd1, 32'h80000000, 32'hffffffff, 0);
        check_val("div_overflow", muldivresp_msg_result, 64'h00000000_80000000);
        do_op(3'd5, 32'h12345678, 32'h9abcdef0, 0);
        check_val("fn_other", muldivresp_msg_result, 64'h0);
        // Long backpressure
        do_op(3'd0, 32'h00001234, 32'hffff0001, 10);

        // Reset in the middle of a DIV (around iteration 10)
        start_op(3'd1, 32'h7654321f, 32'h00000013, acc);
        repeat (11) tick();
        #2 reset_n = 1'b0;
        #1;
        check_val("midcalc_rst_val", 64'(muldivresp_val), 64'd0);
        check_val("midcalc_rst_rdy", 64'(muldivreq_rdy), 64'd0);
        repeat (2) tick();
        check_val("midcalc_rst_rdy2", 64'(muldivreq_rdy), 64'd0);
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (muldivresp_val) stale++;
        end
        check_val("no_stale_resp", 64'(stale), 64'd0);
        do_op(3'd0, 32'd3, 32'd8, 0);
        check_val("mul_after_rst", muldivresp_msg_result, 64'h18);

        // Reset while holding a response in DONE
        start_op(3'd2, 32'h00000100, 32'h00000003, acc);
        repeat (40) tick();
        check_val("done_val", 64'(muldivresp_val), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        check_val("middone_rst_val", 64'(muldivresp_val), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomised mixed stream with random source/sink delays
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            rfn = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2));
            do_op(rfn, rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
